// File: rtl/apb_master_param_if.sv
// Command, response and APB bus bundle for apb_master_param.
// The master modport is the design side; the slave modport is the requester/slave-model side.
interface apb_master_param_if #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SLAVES = 4
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic                         cmd_write;
   logic [ADDR_W-1:0]            cmd_addr;
   logic [DATA_W-1:0]            cmd_wdata;

   logic                         rsp_valid;
   logic [DATA_W-1:0]            rsp_rdata;
   logic                         rsp_err;
   logic                         rsp_timeout;

   logic [NUM_SLAVES-1:0]        PSEL;
   logic                         PENABLE;
   logic                         PWRITE;
   logic [ADDR_W-1:0]            PADDR;
   logic [DATA_W-1:0]            PWDATA;
   logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES-1:0]        PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_param.sv
// Parametrised APB master: one SETUP/ACCESS transfer per command to one of NUM_SLAVES slaves,
// with a one-cycle response pulse reporting slave error, decode error and wait-state timeout.
module apb_master_param #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic               PCLK,
   input  logic               PRESET,
   apb_master_param_if.master bus
);
   localparam int unsigned SLV_W   = (NUM_SLAVES > 2) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   state_e                state_q,       state_d;
   logic [NUM_SLAVES-1:0] psel_q,        psel_d;
   logic                  penable_q,     penable_d;
   logic                  pwrite_q,      pwrite_d;
   logic [ADDR_W-1:0]     paddr_q,       paddr_d;
   logic [DATA_W-1:0]     pwdata_q,      pwdata_d;
   logic                  rsp_valid_q,   rsp_valid_d;
   logic [DATA_W-1:0]     rsp_rdata_q,   rsp_rdata_d;
   logic                  rsp_err_q,     rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;

   logic [SLV_W-1:0]      slv_idx;
   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_W-1:0]     sel_rdata;

   // Address decode to a one-hot select; an out-of-range index leaves dec_sel all zero.
   always_comb begin
      slv_idx = bus.cmd_addr[ADDR_W-1 -: SLV_W];
      dec_sel = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (slv_idx == SLV_W'(i)) dec_sel[i] = 1'b1;
      end
   end

   // Only the currently selected slave's ready/error/data are observed.
   always_comb begin
      sel_ready = |(bus.PREADY  & psel_q);
      sel_err   = |(bus.PSLVERR & psel_q);
      sel_rdata = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (psel_q[i]) sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      wait_cnt_d    = wait_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (|dec_sel) begin
                  state_d    = S_SETUP;
                  psel_d     = dec_sel;
                  penable_d  = 1'b0;
                  pwrite_d   = bus.cmd_write;
                  paddr_d    = bus.cmd_addr;
                  pwdata_d   = bus.cmd_wdata;
                  wait_cnt_d = '0;
               end else begin
                  // Decode error answers immediately without touching the bus.
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
               end
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end
         S_ACCESS: begin
            if (sel_ready) begin
               state_d       = S_IDLE;
               psel_d        = '0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = sel_err;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = (!pwrite_q && !sel_err) ? sel_rdata : '0;
            end else if ((TIMEOUT > 0) && (wait_cnt_q == CNT_W'(TO_LAST))) begin
               state_d       = S_IDLE;
               psel_d        = '0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= S_IDLE;
         psel_q        <= '0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.PSEL        = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PADDR       = paddr_q;
   assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Bench for apb_master_param: a 4-slave/TIMEOUT=4 instance and a 3-slave/no-timeout instance,
// each with a counting slave model and a response scoreboard.
module tb_apb_master_param;
   logic pclk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   apb_master_param_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(4)) a_if ();
   apb_master_param_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(3)) b_if ();

   apb_master_param #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT(4)) u_dut_a (
      .PCLK(pclk), .PRESET(rst_a), .bus(a_if));
   apb_master_param #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT(0)) u_dut_b (
      .PCLK(pclk), .PRESET(rst_b), .bus(b_if));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
      int          due;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          waits;
      logic        serr;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          lat;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];

   // Slave models: selected slave is ready after 'waits' ACCESS cycles; others
   // hold PREADY=1 and PSLVERR=1 so a wrong slave selection shows up.
   int   sa_waits = 0, sa_cnt = 0, sb_waits = 0, sb_cnt = 0;
   logic sa_err = 1'b0, sb_err = 1'b0;

   always @(posedge pclk) begin
      if (a_if.PENABLE && sa_cnt < sa_waits) sa_cnt <= sa_cnt + 1;
      else                                   sa_cnt <= 0;
      if (b_if.PENABLE && sb_cnt < sb_waits) sb_cnt <= sb_cnt + 1;
      else                                   sb_cnt <= 0;
   end

   always_comb begin
      a_if.PREADY = '1;
      a_if.PSLVERR = '1;
      for (int i = 0; i < 4; i++) begin
         if (a_if.PSEL[i]) begin
            a_if.PREADY[i]  = (sa_cnt >= sa_waits);
            a_if.PSLVERR[i] = sa_err;
         end
      end
   end

   always_comb begin
      b_if.PREADY = '1;
      b_if.PSLVERR = '1;
      for (int i = 0; i < 3; i++) begin
         if (b_if.PSEL[i]) begin
            b_if.PREADY[i]  = (sb_cnt >= sb_waits);
            b_if.PSLVERR[i] = sb_err;
         end
      end
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Response monitors: every rsp_valid cycle must match the oldest expected response.
   always @(negedge pclk) begin : mon_a
      exp_t e;
      if (a_if.rsp_valid === 1'b1) begin
         if (qa.size() == 0) begin
            check("a_unexpected_rsp", 64'(1), 64'(0));
         end else begin
            e = qa.pop_front();
            check("a_rsp_rdata",   64'(a_if.rsp_rdata),   64'(e.rdata));
            check("a_rsp_err",     64'(a_if.rsp_err),     64'(e.err));
            check("a_rsp_timeout", 64'(a_if.rsp_timeout), 64'(e.to));
            check("a_rsp_cycle",   64'(cyc),              64'(e.due));
         end
      end
   end

   always @(negedge pclk) begin : mon_b
      exp_t e;
      if (b_if.rsp_valid === 1'b1) begin
         if (qb.size() == 0) begin
            check("b_unexpected_rsp", 64'(1), 64'(0));
         end else begin
            e = qb.pop_front();
            check("b_rsp_rdata",   64'(b_if.rsp_rdata),   64'(e.rdata));
            check("b_rsp_err",     64'(b_if.rsp_err),     64'(e.err));
            check("b_rsp_timeout", 64'(b_if.rsp_timeout), 64'(e.to));
            check("b_rsp_cycle",   64'(cyc),              64'(e.due));
         end
      end
   end

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Drive one command for a single cycle (the accept edge) and queue its expected response.
   task automatic send_a(input vec_t v, input bit track);
      int idx = int'(v.addr[7:6]);
      sa_waits = v.waits;
      sa_err   = v.serr;
      for (int i = 0; i < 4; i++)
         a_if.PRDATA[i*32 +: 32] = (i == idx) ? v.rdata : (32'hBAD0_0000 | 32'(i));
      a_if.cmd_valid = 1'b1;
      a_if.cmd_write = v.wr;
      a_if.cmd_addr  = v.addr;
      a_if.cmd_wdata = v.wdata;
      check("a_cmd_ready_at_accept", 64'(a_if.cmd_ready), 64'(1));
      if (track) qa.push_back('{v.exp_rdata, v.exp_err, v.exp_to, cyc + v.lat});
      step();
      a_if.cmd_valid = 1'b0;
   endtask

   task automatic send_b(input vec_t v);
      int idx = int'(v.addr[7:6]);
      sb_waits = v.waits;
      sb_err   = v.serr;
      for (int i = 0; i < 3; i++)
         b_if.PRDATA[i*32 +: 32] = (i == idx) ? v.rdata : (32'hBAD0_0000 | 32'(i));
      b_if.cmd_valid = 1'b1;
      b_if.cmd_write = v.wr;
      b_if.cmd_addr  = v.addr;
      b_if.cmd_wdata = v.wdata;
      check("b_cmd_ready_at_accept", 64'(b_if.cmd_ready), 64'(1));
      qb.push_back('{v.exp_rdata, v.exp_err, v.exp_to, cyc + v.lat});
      step();
      b_if.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() > 0 || qb.size() > 0) && n < 60) begin
         step();
         n++;
      end
      check("rsp_arrived_a", 64'(qa.size()), 64'(0));
      check("rsp_arrived_b", 64'(qb.size()), 64'(0));
      qa.delete();
      qb.delete();
   endtask

   vec_t vecs[8];
   vec_t v;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // wr addr wdata waits serr prdata | exp_rdata exp_err exp_to latency
      vecs[0] = '{1'b1, 8'h45, 32'hDEADBEEF, 0,    1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 8'hC3, 32'h0,        2,    1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 5};
      vecs[2] = '{1'b0, 8'h10, 32'h0,        0,    1'b1, 32'h55555555, 32'h0,        1'b1, 1'b0, 3};
      vecs[3] = '{1'b1, 8'h80, 32'h0BB0,     1000, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 6};
      vecs[4] = '{1'b0, 8'h7F, 32'h0,        3,    1'b0, 32'hA5A50001, 32'hA5A50001, 1'b0, 1'b0, 6};
      vecs[5] = '{1'b1, 8'h20, 32'h77,       1,    1'b1, 32'h0,        32'h0,        1'b1, 1'b0, 4};
      vecs[6] = '{1'b0, 8'hFF, 32'h0,        0,    1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 3};
      vecs[7] = '{1'b0, 8'h40, 32'h0,        1000, 1'b0, 32'h99999999, 32'h0,        1'b1, 1'b1, 6};

      a_if.cmd_valid = 1'b0; a_if.cmd_write = 1'b0; a_if.cmd_addr = '0; a_if.cmd_wdata = '0;
      a_if.PRDATA = '0;
      b_if.cmd_valid = 1'b0; b_if.cmd_write = 1'b0; b_if.cmd_addr = '0; b_if.cmd_wdata = '0;
      b_if.PRDATA = '0;

      // Reset values while PRESET is held.
      step(); step();
      check("rst_psel",        64'(a_if.PSEL),        64'(0));
      check("rst_penable",     64'(a_if.PENABLE),     64'(0));
      check("rst_pwrite",      64'(a_if.PWRITE),      64'(0));
      check("rst_paddr",       64'(a_if.PADDR),       64'(0));
      check("rst_pwdata",      64'(a_if.PWDATA),      64'(0));
      check("rst_rsp_valid",   64'(a_if.rsp_valid),   64'(0));
      check("rst_rsp_rdata",   64'(a_if.rsp_rdata),   64'(0));
      check("rst_rsp_err",     64'(a_if.rsp_err),     64'(0));
      check("rst_rsp_timeout", 64'(a_if.rsp_timeout), 64'(0));
      rst_a = 1'b0;
      rst_b = 1'b0;
      check("cmd_ready_after_rst", 64'(a_if.cmd_ready), 64'(1));

      // Plain write: phase timing and signal stability.
      send_a(vecs[0], 1'b1);
      check("t1_psel_setup",    64'(a_if.PSEL),    64'(4'b0010));
      check("t1_penable_setup", 64'(a_if.PENABLE), 64'(0));
      check("t1_pwrite",        64'(a_if.PWRITE),  64'(1));
      check("t1_paddr_setup",   64'(a_if.PADDR),   64'(8'h45));
      check("t1_pwdata_setup",  64'(a_if.PWDATA),  64'(32'hDEADBEEF));
      check("t1_cmd_ready_busy", 64'(a_if.cmd_ready), 64'(0));
      step();
      check("t1_penable_access", 64'(a_if.PENABLE), 64'(1));
      check("t1_psel_access",    64'(a_if.PSEL),    64'(4'b0010));
      check("t1_paddr_access",   64'(a_if.PADDR),   64'(8'h45));
      check("t1_pwdata_access",  64'(a_if.PWDATA),  64'(32'hDEADBEEF));
      step();
      check("t1_psel_done",    64'(a_if.PSEL),    64'(0));
      check("t1_penable_done", 64'(a_if.PENABLE), 64'(0));
      check("t1_paddr_kept",   64'(a_if.PADDR),   64'(8'h45));
      drain();

      // Read with two wait states: ACCESS held T+2..T+4.
      send_a(vecs[1], 1'b1);
      check("t2_psel", 64'(a_if.PSEL), 64'(4'b1000));
      for (int k = 2; k <= 4; k++) begin
         step();
         check("t2_penable_wait", 64'(a_if.PENABLE), 64'(1));
      end
      step();
      check("t2_penable_done", 64'(a_if.PENABLE), 64'(0));
      drain();

      // Timeout then a command accepted in the response cycle.
      send_a(vecs[3], 1'b1);
      for (int k = 2; k <= 5; k++) begin
         step();
         check("t4_penable_access", 64'(a_if.PENABLE), 64'(1));
         check("t4_psel_access",    64'(a_if.PSEL),    64'(4'b0100));
      end
      step();
      check("t4_psel_abort",  64'(a_if.PSEL),      64'(0));
      check("t4_ready_in_rsp", 64'(a_if.cmd_ready), 64'(1));
      check("t4_rsp_valid",   64'(a_if.rsp_valid), 64'(1));
      v = '{1'b1, 8'h01, 32'h1111, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3};
      send_a(v, 1'b1);
      check("t4_next_setup", 64'(a_if.PSEL), 64'(4'b0001));
      drain();

      // Table of independent transfers.
      foreach (vecs[i]) begin
         send_a(vecs[i], 1'b1);
         drain();
      end

      // Reset during an ACCESS wait state: no response for the aborted command.
      send_a(vecs[7], 1'b0);
      step();
      step();
      rst_a = 1'b1;
      a_if.cmd_valid = 1'b1;
      a_if.cmd_addr  = 8'h00;
      step();
      check("t6_psel_rst",      64'(a_if.PSEL),      64'(0));
      check("t6_penable_rst",   64'(a_if.PENABLE),   64'(0));
      check("t6_paddr_rst",     64'(a_if.PADDR),     64'(0));
      check("t6_rsp_valid_rst", 64'(a_if.rsp_valid), 64'(0));
      rst_a = 1'b0;
      a_if.cmd_valid = 1'b0;
      check("t6_cmd_ready", 64'(a_if.cmd_ready), 64'(1));
      step();
      step();
      v = '{1'b1, 8'h30, 32'h0000ABCD, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3};
      send_a(v, 1'b1);
      drain();

      // Three slaves: index 3 is a decode error; TIMEOUT=0 allows long waits.
      v = '{1'b0, 8'hC0, 32'h0, 0, 1'b0, 32'h77, 32'h0, 1'b1, 1'b0, 1};
      send_b(v);
      check("t5_psel_zero",  64'(b_if.PSEL),      64'(0));
      check("t5_cmd_ready",  64'(b_if.cmd_ready), 64'(1));
      step();
      check("t5_psel_after", 64'(b_if.PSEL),      64'(0));
      drain();
      v = '{1'b1, 8'hFF, 32'h5, 0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      send_b(v);
      drain();
      v = '{1'b0, 8'h80, 32'h0, 20, 1'b0, 32'h600DF00D, 32'h600DF00D, 1'b0, 1'b0, 23};
      send_b(v);
      drain();
      v = '{1'b0, 8'h41, 32'h0, 0, 1'b0, 32'h13579BDF, 32'h13579BDF, 1'b0, 1'b0, 3};
      send_b(v);
      check("b_psel_slave1", 64'(b_if.PSEL), 64'(3'b010));
      drain();

      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/apb_master_param.md
Name: apb_master_param

Overview:
Parametrised APB master, the multi-slave successor to the two-slave APB master. It accepts single read/write commands on a valid/ready command port and runs one APB SETUP→ACCESS transfer to one of NUM_SLAVES slaves, selected by the top address bits. It returns the result on a one-cycle response pulse, with slave-error, decode-error and wait-state-timeout reporting.

Parameters:
ADDR_W, 8, width of cmd_addr and PADDR
DATA_W, 32, width of write/read data
NUM_SLAVES, 4, number of PSEL lines (2..16); SLV_W = max(1, clog2(NUM_SLAVES)) is a derived localparam
TIMEOUT, 16, maximum number of ACCESS cycles per transfer; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address; slave index = cmd_addr[ADDR_W-1 -: SLV_W]
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  DATA_W  read data; 0 for writes and for errors
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  NUM_SLAVES*DATA_W  read data; slave i occupies bits [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- All outputs are registered. Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, state=IDLE, wait counter=0. cmd_ready is combinational from state, so it is 1 in the first cycle after PRESET falls.
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. A command is accepted at edge T when cmd_valid=1 and cmd_ready=1. cmd_valid is ignored while PRESET=1.
  - If the slave index < NUM_SLAVES: at T+1, state=SETUP; PSEL[idx]=1, PENABLE=0; PADDR, PWRITE and PWDATA are loaded from the command.
  - If the slave index >= NUM_SLAVES (decode error): no APB activity and state stays IDLE. At T+1: rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP lasts exactly one cycle, then ACCESS with PENABLE=1. PSEL, PADDR, PWRITE and PWDATA are held stable from SETUP through the last ACCESS cycle.
- ACCESS: PREADY[idx] and PSLVERR[idx] are sampled at each edge. Inputs from non-selected slaves are ignored.
  - PREADY[idx]=1: the transfer completes. Next cycle: state=IDLE, PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR[idx], rsp_timeout=0. rsp_rdata = PRDATA slice of idx for a read with no error; otherwise 0.
  - PREADY[idx]=0: wait counter increments.
  - Timeout: if TIMEOUT>0 and PREADY[idx] is still low at the end of the TIMEOUT-th ACCESS cycle, the transfer is aborted. Next cycle: state=IDLE, PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The wait counter clears on entry to SETUP.
- Latency with no wait states: command accept to rsp_valid = 3 cycles (SETUP, ACCESS, response). Each wait state adds 1 cycle.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- A response cycle is an IDLE cycle, so a new command may be accepted in the same cycle that rsp_valid=1.
- After a transfer, PADDR, PWDATA and PWRITE retain their last values; only PSEL and PENABLE drop.
- Reset mid-transfer (any state): at the next edge every output takes its reset value. No response is issued for the aborted command.

Test Plan:
1. NUM_SLAVES=4, ADDR_W=8, DATA_W=32. Write addr 0x45, data 0xDEADBEEF, PREADY=4'hF → PSEL=4'b0010 at T+1, PENABLE=1 at T+2, rsp_valid=1 at T+3 with rsp_err=0 and rsp_rdata=0; PADDR=0x45 and PWDATA=0xDEADBEEF stable from T+1 to T+2.
2. Read addr 0xC3; slave 3 holds PREADY low for 2 ACCESS cycles; PRDATA slice 3 = 0x12345678 → PENABLE high from T+2 to T+4, rsp_valid at T+5 with rsp_rdata=0x12345678 and rsp_err=0.
3. Read addr 0x10; slave 0 returns PREADY=1 and PSLVERR=1 → rsp_valid at T+3 with rsp_err=1, rsp_timeout=0, rsp_rdata=0. PSLVERR pulses on other slaves during the transfer have no effect.
4. TIMEOUT=4. Write addr 0x80; PREADY[2] stuck at 0 → ACCESS lasts T+2 to T+5, PSEL=0 at T+6, rsp_valid=1 with rsp_err=1 and rsp_timeout=1; the next command is accepted at T+6.
5. NUM_SLAVES=3. Command addr 0xC0 → PSEL stays 0 throughout; rsp_valid at T+1 with rsp_err=1, rsp_timeout=0; cmd_ready stays 1.
6. Assert PRESET=1 during an ACCESS wait state → next edge PSEL=0, PENABLE=0, and no rsp_valid ever issued for that command. After PRESET returns to 0, cmd_ready=1 and a new write completes normally in 3 cycles.
